// File: rtl/out_buffer_feeder_if.sv
// rtl/out_buffer_feeder_if.sv - row write, drain and transpose handshake bundle for out_buffer_feeder
interface out_buffer_feeder_if #(
  parameter int ROW_DIM    = 16,
  parameter int COL_DIM    = 16,
  parameter int DATA_WIDTH = 8
);
  localparam int AW = $clog2(COL_DIM);
  localparam int RW = ROW_DIM * DATA_WIDTH;

  logic [AW-1:0] A;
  logic [AW-1:0] B;
  logic          wr_valid;
  logic [RW-1:0] wr_data;
  logic          wr_ready;
  logic          drain_start;
  logic          T_end;
  logic          T_start;
  logic [RW-1:0] data_out;
  logic          busy;
  logic          done;

  modport slave (
    input  A, B, wr_valid, wr_data, drain_start, T_end,
    output wr_ready, T_start, data_out, busy, done
  );

  modport master (
    output A, B, wr_valid, wr_data, drain_start, T_end,
    input  wr_ready, T_start, data_out, busy, done
  );
endinterface

// File: rtl/out_buffer_feeder.sv
// rtl/out_buffer_feeder.sv - tile row buffer that captures array rows and streams masked rows to transpose
module out_buffer_feeder #(
  parameter int ROW_DIM    = 16,
  parameter int COL_DIM    = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  out_buffer_feeder_if.slave  bus
);
  localparam int AW = $clog2(COL_DIM);
  localparam int RW = ROW_DIM * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FULL,
    DRAIN,
    WAIT_END
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [AW-1:0] a_q;
  logic [AW-1:0] b_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [RW-1:0] mem [COL_DIM];

  logic          wr_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] rd_row;
  logic [RW-1:0] row_masked;

  logic          t_start_q;
  logic [RW-1:0] data_out_q;
  logic          done_q;

  // State register; reset abandons any tile in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, write handshake and buffer write strobe
  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = wr_ptr;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        // A zero-row tile is dropped without leaving IDLE
        if (bus.wr_valid && (bus.B != '0)) begin
          mem_we     = 1'b1;
          mem_addr   = '0;
          state_next = (bus.B == AW'(1)) ? FULL : FILL;
        end
      end
      FILL: begin
        wr_ready = 1'b1;
        if (bus.wr_valid) begin
          mem_we = 1'b1;
          if (wr_ptr == (b_q - AW'(1))) begin
            state_next = FULL;
          end
        end
      end
      FULL: begin
        if (bus.drain_start) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_ptr == (b_q - AW'(1))) begin
          state_next = WAIT_END;
        end
      end
      WAIT_END: begin
        if (bus.T_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Lanes at or above the latched active width are zeroed before leaving the block
  always_comb begin
    rd_row     = mem[rd_ptr];
    row_masked = '0;
    for (int k = 0; k < ROW_DIM; k++) begin
      if (k < int'(a_q)) begin
        row_masked[k*DATA_WIDTH +: DATA_WIDTH] = rd_row[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Row storage; contents are don't-care after reset so it carries no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= bus.wr_data;
    end
  end

  // Dimension latches, pointers and registered stream outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      t_start_q  <= 1'b0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= (state == WAIT_END) && bus.T_end;
      t_start_q  <= (state == DRAIN);
      data_out_q <= (state == DRAIN) ? row_masked : '0;
      case (state)
        IDLE: begin
          if (mem_we) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            wr_ptr <= AW'(1);
          end
        end
        FILL: begin
          if (mem_we) begin
            wr_ptr <= wr_ptr + AW'(1);
          end
        end
        FULL: begin
          if (bus.drain_start) begin
            rd_ptr <= '0;
          end
        end
        DRAIN: begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.busy     = (state != IDLE);
  assign bus.T_start  = t_start_q;
  assign bus.data_out = data_out_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_out_buffer_feeder.sv
// tb/tb_out_buffer_feeder.sv - self-checking bench for out_buffer_feeder
module tb_out_buffer_feeder;
  localparam int ROW_DIM    = 16;
  localparam int COL_DIM    = 16;
  localparam int DATA_WIDTH = 8;
  localparam int RW         = ROW_DIM * DATA_WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  out_buffer_feeder_if #(.ROW_DIM(ROW_DIM), .COL_DIM(COL_DIM), .DATA_WIDTH(DATA_WIDTH)) bus ();

  out_buffer_feeder #(.ROW_DIM(ROW_DIM), .COL_DIM(COL_DIM), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] tile_rows [COL_DIM];

  typedef struct {
    int          a;
    int          b;
    int          n_writes;
    int          exp_len;
    logic [15:0] exp_keep;
  } vec_t;

  vec_t vecs [6];

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_row(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] lane_keep(input logic [RW-1:0] row, input logic [15:0] keep);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < ROW_DIM; k++) begin
      if (keep[k]) r[k*DATA_WIDTH +: DATA_WIDTH] = row[k*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  function automatic logic [15:0] keep_for(input int a);
    logic [31:0] m;
    m = (32'd1 << a) - 32'd1;
    return m[15:0];
  endfunction

  task automatic idle_inputs();
    bus.wr_valid    = 1'b0;
    bus.drain_start = 1'b0;
    bus.T_end       = 1'b0;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < COL_DIM; i++)
      for (int k = 0; k < ROW_DIM; k++)
        tile_rows[i][k*DATA_WIDTH +: DATA_WIDTH] = 8'(16 * i + k);
  endtask

  task automatic fill_random();
    for (int i = 0; i < COL_DIM; i++)
      tile_rows[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic write_tile(input int a, input int b, input int n, input bit stray, input bit drain_on_last);
    for (int i = 0; i < n; i++) begin
      if (stray) begin
        repeat ($urandom_range(0, 2)) begin
          bus.wr_valid    = 1'b0;
          bus.T_end       = 1'($urandom_range(0, 1));
          bus.drain_start = 1'($urandom_range(0, 1));
          tick();
        end
      end
      bus.T_end       = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.drain_start = (drain_on_last && (i == n - 1)) || (stray && ($urandom_range(0, 1) == 1));
      bus.wr_valid    = 1'b1;
      bus.wr_data     = tile_rows[i];
      bus.A           = (i == 0 || !stray) ? 4'(a) : 4'($urandom);
      bus.B           = (i == 0 || !stray) ? 4'(b) : 4'($urandom);
      check1("wr_ready_during_fill", bus.wr_ready, 1'b1);
      tick();
      if (b == 0) check1("busy_stays_low_b0", bus.busy, 1'b0);
    end
    idle_inputs();
  endtask

  task automatic drain_tile(input int len, input logic [15:0] keep, input bit stray);
    check1("full_wr_ready", bus.wr_ready, 1'b0);
    check1("full_busy", bus.busy, 1'b1);
    check1("full_no_stream", bus.T_start, 1'b0);
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    bus.T_end       = stray ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    for (int i = 0; i < len; i++) begin
      check1("stream_t_start", bus.T_start, 1'b1);
      check_row("stream_row", bus.data_out, lane_keep(tile_rows[i], keep));
      bus.T_end       = (stray && (i <= len - 2)) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.drain_start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    idle_inputs();
    check1("stream_end_t_start", bus.T_start, 1'b0);
    check_row("stream_end_data", bus.data_out, '0);
    check1("wait_end_busy", bus.busy, 1'b1);
  endtask

  task automatic finish_tile(input int gap, input bit settle);
    repeat (gap) tick();
    check1("wait_end_no_done", bus.done, 1'b0);
    bus.T_end = 1'b1;
    tick();
    bus.T_end = 1'b0;
    check1("done_pulse", bus.done, 1'b1);
    check1("idle_after_done", bus.busy, 1'b0);
    check1("wr_ready_after_done", bus.wr_ready, 1'b1);
    if (settle) begin
      tick();
      check1("done_one_cycle", bus.done, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{a: 10, b: 10, n_writes: 10, exp_len: 10, exp_keep: 16'h03FF};
    vecs[1] = '{a: 0,  b: 1,  n_writes: 1,  exp_len: 1,  exp_keep: 16'h0000};
    vecs[2] = '{a: 15, b: 15, n_writes: 15, exp_len: 15, exp_keep: 16'h7FFF};
    vecs[3] = '{a: 3,  b: 2,  n_writes: 2,  exp_len: 2,  exp_keep: 16'h0007};
    vecs[4] = '{a: 5,  b: 0,  n_writes: 3,  exp_len: 0,  exp_keep: 16'h0000};
    vecs[5] = '{a: 1,  b: 3,  n_writes: 3,  exp_len: 3,  exp_keep: 16'h0001};

    reset       = 1'b0;
    bus.A       = '0;
    bus.B       = '0;
    bus.wr_data = '0;
    idle_inputs();
    tick();
    tick();
    check1("reset_t_start", bus.T_start, 1'b0);
    check_row("reset_data_out", bus.data_out, '0);
    check1("reset_done", bus.done, 1'b0);
    check1("reset_busy", bus.busy, 1'b0);
    check1("reset_wr_ready", bus.wr_ready, 1'b1);
    reset = 1'b1;
    tick();

    // drain_start while idle must not start anything
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    check1("idle_drain_ignored", bus.busy, 1'b0);

    foreach (vecs[v]) begin
      fill_pattern();
      write_tile(vecs[v].a, vecs[v].b, vecs[v].n_writes, 1'b0, 1'b0);
      if (vecs[v].exp_len == 0) begin
        bus.drain_start = 1'b1;
        tick();
        bus.drain_start = 1'b0;
        check1("b0_no_drain", bus.T_start, 1'b0);
        check1("b0_still_idle", bus.busy, 1'b0);
      end else begin
        drain_tile(vecs[v].exp_len, vecs[v].exp_keep, 1'b0);
        finish_tile(vecs[v].exp_len, 1'b1);
      end
    end

    // Backpressure: drain with the final write is ignored and a fifth row is refused
    fill_pattern();
    write_tile(8, 4, 4, 1'b0, 1'b1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = {RW{1'b1}};
    check1("bp_wr_ready_low", bus.wr_ready, 1'b0);
    tick();
    tick();
    bus.wr_valid = 1'b0;
    check1("bp_early_drain_ignored", bus.T_start, 1'b0);
    check1("bp_still_full", bus.busy, 1'b1);
    drain_tile(4, keep_for(8), 1'b0);
    finish_tile(3, 1'b1);

    // Reset during the third drain cycle
    fill_pattern();
    write_tile(12, 6, 6, 1'b0, 1'b0);
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    tick();
    tick();
    check1("pre_reset_streaming", bus.T_start, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check1("mid_reset_t_start", bus.T_start, 1'b0);
    check_row("mid_reset_data_out", bus.data_out, '0);
    check1("mid_reset_busy", bus.busy, 1'b0);
    check1("mid_reset_wr_ready", bus.wr_ready, 1'b1);
    fill_random();
    write_tile(7, 5, 5, 1'b0, 1'b0);
    drain_tile(5, keep_for(7), 1'b0);
    finish_tile(2, 1'b1);

    // Back-to-back: next tile's first row lands in the done cycle
    fill_random();
    write_tile(9, 3, 3, 1'b0, 1'b0);
    drain_tile(3, keep_for(9), 1'b0);
    finish_tile(1, 1'b0);
    fill_random();
    write_tile(4, 7, 7, 1'b0, 1'b0);
    drain_tile(7, keep_for(4), 1'b0);
    finish_tile(0, 1'b1);

    // Random tiles with stray handshakes, gaps and mid-tile A/B churn
    for (int t = 0; t < 20; t++) begin
      int ra;
      int rb;
      ra = $urandom_range(0, 15);
      rb = $urandom_range(1, 15);
      fill_random();
      write_tile(ra, rb, rb, 1'b1, 1'b0);
      drain_tile(rb, keep_for(ra), 1'b1);
      finish_tile($urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
